// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong engine: FSM states, direction
// encodings and the joystick centre value.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    typedef logic dir_t;

    localparam dir_t LEFT  = 1'b0;
    localparam dir_t RIGHT = 1'b1;
    localparam dir_t UP    = 1'b0;
    localparam dir_t DOWN  = 1'b1;

    localparam logic [7:0] JOY_CENTRE = 8'd128;

endpackage

// File: rtl/pong_paddle_mover.sv
// Paddle motion: converts a joystick reading into a step and produces the
// clamped next paddle top y for the current frame.
module pong_paddle_mover
    import pong_pkg::*;
#(
    parameter int POS_W       = 11,
    parameter int V_RES       = 480,
    parameter int PADDLE_H    = 100,
    parameter int SPEED_SHIFT = 5
) (
    input  logic [7:0]       joy,
    input  logic [POS_W-1:0] y,
    input  logic             frame_tick,
    output logic [POS_W-1:0] y_next
);

    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_RES - PADDLE_H);

    logic [7:0]       mag_s;
    logic [POS_W-1:0] step_s;
    logic [POS_W:0]   down_sum_s;

    // Step size and clamped next position; the paddle holds between ticks
    always_comb begin
        mag_s      = 8'd0;
        step_s     = {POS_W{1'b0}};
        down_sum_s = {(POS_W+1){1'b0}};
        y_next     = y;
        if (joy >= JOY_CENTRE) begin
            mag_s = joy - JOY_CENTRE;
        end else begin
            mag_s = JOY_CENTRE - joy;
        end
        step_s     = POS_W'(mag_s >> SPEED_SHIFT);
        down_sum_s = {1'b0, y} + {1'b0, step_s};
        if (!frame_tick) begin
            y_next = y;
        end else if (joy >= JOY_CENTRE) begin
            if (y < step_s) begin
                y_next = {POS_W{1'b0}};
            end else begin
                y_next = y - step_s;
            end
        end else begin
            if (down_sum_s > {1'b0, Y_MAX}) begin
                y_next = Y_MAX;
            end else begin
                y_next = down_sum_s[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pong_engine_param.sv
// Parametrised Pong game engine advancing physics once per frame_tick.
// Optional build macro PONG_BALL_SPEEDUP_EN: each paddle hit speeds the ball up to MAX_VX.
module pong_engine_param
    import pong_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int POS_W       = 11,
    parameter int PADDLE_H    = 100,
    parameter int PADDLE_W    = 5,
    parameter int BALL_SIZE   = 10,
    parameter int BALL_VX0    = 6,
    parameter int BALL_VY0    = 3,
    parameter int MAX_VX      = 15,
    parameter int SPEED_SHIFT = 5,
    parameter int SCORE_W     = 8,
    parameter int WIN_SCORE   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [7:0]         joy_y1,
    input  logic [7:0]         joy_y2,
    output logic [POS_W-1:0]   ball_x,
    output logic [POS_W-1:0]   ball_y,
    output logic [POS_W-1:0]   p1_y,
    output logic [POS_W-1:0]   p2_y,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         state_out,
    output logic               winner,
    output logic               hit_pulse,
    output logic               point_pulse
);

    localparam int EW = POS_W + 1;

    localparam logic [POS_W-1:0] CX          = POS_W'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] CY          = POS_W'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] PY0         = POS_W'((V_RES - PADDLE_H) / 2);
    localparam logic [POS_W-1:0] VX0         = POS_W'(BALL_VX0);
    localparam logic [POS_W-1:0] VY          = POS_W'(BALL_VY0);
    localparam logic [POS_W-1:0] VX_MAX      = POS_W'(MAX_VX);
    localparam logic [POS_W-1:0] LEFT_HIT_X  = POS_W'(PADDLE_W);
    localparam logic [POS_W-1:0] RIGHT_HIT_X = POS_W'(H_RES - PADDLE_W - BALL_SIZE);
    localparam logic [POS_W-1:0] BOTTOM_Y    = POS_W'(V_RES - BALL_SIZE);
    localparam logic [EW-1:0]    RIGHT_EDGE_E = EW'(H_RES - PADDLE_W);
    localparam logic [EW-1:0]    V_RES_E     = EW'(V_RES);
    localparam logic [EW-1:0]    BALL_E      = EW'(BALL_SIZE);
    localparam logic [EW-1:0]    PH_E        = EW'(PADDLE_H);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
`ifdef PONG_BALL_SPEEDUP_EN
    localparam logic [POS_W-1:0] VX_INC      = POS_W'(1);
`else
    localparam logic [POS_W-1:0] VX_INC      = POS_W'(0);
`endif

    state_t             state_r, state_n_s;
    logic [POS_W-1:0]   ball_x_r, ball_y_r, p1_y_r, p2_y_r, vx_r;
    logic [POS_W-1:0]   bx_n_s, by_n_s, p1_n_s, p2_n_s, vx_n_s;
    logic [SCORE_W-1:0] s1_r, s2_r, s1_n_s, s2_n_s;
    dir_t               xdir_r, ydir_r, sdir_r, xdir_n_s, ydir_n_s, sdir_n_s;
    logic               winner_r, win_n_s, hit_r, hit_n_s, pt_r, pt_n_s;
    logic               start_q_r, start_evt_r, pending_r, pending_s, pending_n_s;
    logic [POS_W-1:0]   p1_mv_s, p2_mv_s, vx_hit_s;
    logic [EW-1:0]      vx_sum_s;
    logic [SCORE_W-1:0] s1_inc_s, s2_inc_s;
    logic               left_trig_s, right_trig_s, p1_ovl_s, p2_ovl_s, bottom_s, top_s;

    pong_paddle_mover #(
        .POS_W(POS_W), .V_RES(V_RES), .PADDLE_H(PADDLE_H), .SPEED_SHIFT(SPEED_SHIFT)
    ) u_mover_p1 (
        .joy(joy_y1), .y(p1_y_r), .frame_tick(frame_tick), .y_next(p1_mv_s)
    );

    pong_paddle_mover #(
        .POS_W(POS_W), .V_RES(V_RES), .PADDLE_H(PADDLE_H), .SPEED_SHIFT(SPEED_SHIFT)
    ) u_mover_p2 (
        .joy(joy_y2), .y(p2_y_r), .frame_tick(frame_tick), .y_next(p2_mv_s)
    );

    // Collision tests are done one bit wider so edge sums cannot wrap
    assign pending_s    = pending_r | start_evt_r;
    assign left_trig_s  = {1'b0, ball_x_r} < ({1'b0, LEFT_HIT_X} + {1'b0, vx_r});
    assign right_trig_s = ({1'b0, ball_x_r} + BALL_E + {1'b0, vx_r}) > RIGHT_EDGE_E;
    assign p1_ovl_s     = (({1'b0, ball_y_r} + BALL_E) > {1'b0, p1_y_r}) &&
                          ({1'b0, ball_y_r} < ({1'b0, p1_y_r} + PH_E));
    assign p2_ovl_s     = (({1'b0, ball_y_r} + BALL_E) > {1'b0, p2_y_r}) &&
                          ({1'b0, ball_y_r} < ({1'b0, p2_y_r} + PH_E));
    assign bottom_s     = ({1'b0, ball_y_r} + BALL_E + {1'b0, VY}) >= V_RES_E;
    assign top_s        = ball_y_r < VY;
    assign vx_sum_s     = {1'b0, vx_r} + {1'b0, VX_INC};
    assign vx_hit_s     = (vx_sum_s > {1'b0, VX_MAX}) ? vx_r : vx_sum_s[POS_W-1:0];
    assign s1_inc_s     = (s1_r == SCORE_MAX) ? s1_r : s1_r + SCORE_W'(1);
    assign s2_inc_s     = (s2_r == SCORE_MAX) ? s2_r : s2_r + SCORE_W'(1);

    // Next-state and next-output logic; everything advances only on frame_tick
    always_comb begin
        state_n_s   = state_r;
        bx_n_s      = ball_x_r;
        by_n_s      = ball_y_r;
        p1_n_s      = p1_y_r;
        p2_n_s      = p2_y_r;
        vx_n_s      = vx_r;
        s1_n_s      = s1_r;
        s2_n_s      = s2_r;
        win_n_s     = winner_r;
        xdir_n_s    = xdir_r;
        ydir_n_s    = ydir_r;
        sdir_n_s    = sdir_r;
        hit_n_s     = 1'b0;
        pt_n_s      = 1'b0;
        pending_n_s = pending_s;
        if (frame_tick) begin
            // A pending start is consumed or, in PLAY, discarded on every tick
            pending_n_s = 1'b0;
            case (state_r)
                IDLE: begin
                    bx_n_s = CX;
                    by_n_s = CY;
                    p1_n_s = PY0;
                    p2_n_s = PY0;
                    s1_n_s = {SCORE_W{1'b0}};
                    s2_n_s = {SCORE_W{1'b0}};
                    if (pending_s) begin
                        state_n_s = SERVE;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                SERVE: begin
                    bx_n_s   = CX;
                    by_n_s   = CY;
                    p1_n_s   = PY0;
                    p2_n_s   = PY0;
                    vx_n_s   = VX0;
                    xdir_n_s = sdir_r;
                    ydir_n_s = DOWN;
                    if (pending_s) begin
                        state_n_s = PLAY;
                    end else begin
                        state_n_s = SERVE;
                    end
                end
                PLAY: begin
                    p1_n_s = p1_mv_s;
                    p2_n_s = p2_mv_s;
                    if (ydir_r == DOWN) begin
                        if (bottom_s) begin
                            by_n_s   = BOTTOM_Y;
                            ydir_n_s = UP;
                        end else begin
                            by_n_s = ball_y_r + VY;
                        end
                    end else begin
                        if (top_s) begin
                            by_n_s   = {POS_W{1'b0}};
                            ydir_n_s = DOWN;
                        end else begin
                            by_n_s = ball_y_r - VY;
                        end
                    end
                    // On a miss the ball stays at the edge until the next serve
                    if (xdir_r == LEFT) begin
                        if (!left_trig_s) begin
                            bx_n_s = ball_x_r - vx_r;
                        end else if (p1_ovl_s) begin
                            bx_n_s   = LEFT_HIT_X;
                            xdir_n_s = RIGHT;
                            vx_n_s   = vx_hit_s;
                            hit_n_s  = 1'b1;
                        end else begin
                            s2_n_s   = s2_inc_s;
                            pt_n_s   = 1'b1;
                            sdir_n_s = LEFT;
                            if (s2_inc_s == WIN) begin
                                state_n_s = GAME_OVER;
                                win_n_s   = 1'b1;
                            end else begin
                                state_n_s = SERVE;
                            end
                        end
                    end else begin
                        if (!right_trig_s) begin
                            bx_n_s = ball_x_r + vx_r;
                        end else if (p2_ovl_s) begin
                            bx_n_s   = RIGHT_HIT_X;
                            xdir_n_s = LEFT;
                            vx_n_s   = vx_hit_s;
                            hit_n_s  = 1'b1;
                        end else begin
                            s1_n_s   = s1_inc_s;
                            pt_n_s   = 1'b1;
                            sdir_n_s = RIGHT;
                            if (s1_inc_s == WIN) begin
                                state_n_s = GAME_OVER;
                                win_n_s   = 1'b0;
                            end else begin
                                state_n_s = SERVE;
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    if (pending_s) begin
                        state_n_s = IDLE;
                        bx_n_s    = CX;
                        by_n_s    = CY;
                        p1_n_s    = PY0;
                        p2_n_s    = PY0;
                        s1_n_s    = {SCORE_W{1'b0}};
                        s2_n_s    = {SCORE_W{1'b0}};
                    end else begin
                        state_n_s = GAME_OVER;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Start-button edge detector; the level is tracked through reset so no edge leaks out of it
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q_r   <= start;
            start_evt_r <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            start_q_r   <= start;
            start_evt_r <= start & ~start_q_r;
            pending_r   <= pending_n_s;
        end
    end

    // Game state, positions, scores and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ball_x_r <= CX;
            ball_y_r <= CY;
            p1_y_r   <= PY0;
            p2_y_r   <= PY0;
            vx_r     <= VX0;
            s1_r     <= {SCORE_W{1'b0}};
            s2_r     <= {SCORE_W{1'b0}};
            winner_r <= 1'b0;
            xdir_r   <= LEFT;
            ydir_r   <= DOWN;
            sdir_r   <= LEFT;
            hit_r    <= 1'b0;
            pt_r     <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            ball_x_r <= bx_n_s;
            ball_y_r <= by_n_s;
            p1_y_r   <= p1_n_s;
            p2_y_r   <= p2_n_s;
            vx_r     <= vx_n_s;
            s1_r     <= s1_n_s;
            s2_r     <= s2_n_s;
            winner_r <= win_n_s;
            xdir_r   <= xdir_n_s;
            ydir_r   <= ydir_n_s;
            sdir_r   <= sdir_n_s;
            hit_r    <= hit_n_s;
            pt_r     <= pt_n_s;
        end
    end

    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;
    assign p1_y        = p1_y_r;
    assign p2_y        = p2_y_r;
    assign p1_score    = s1_r;
    assign p2_score    = s2_r;
    assign state_out   = state_r;
    assign winner      = winner_r;
    assign hit_pulse   = hit_r;
    assign point_pulse = pt_r;

endmodule

// File: tb/tb_pong_engine_param.sv
// Directed bench for pong_engine_param: a vector table for start/paddle basics,
// then hand-computed rallies covering hits, misses, bounces, game over and reset.
module tb_pong_engine_param;

    logic        clk = 1'b0;
    logic        rst, frame_tick, start;
    logic [7:0]  joy_y1, joy_y2;
    logic [10:0] ball_x, ball_y, p1_y, p2_y;
    logic [7:0]  p1_score, p2_score;
    logic [1:0]  state_out;
    logic        winner, hit_pulse, point_pulse;

    int checks = 0;
    int errors = 0;

    pong_engine_param dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .joy_y1(joy_y1), .joy_y2(joy_y2),
        .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
        .p1_score(p1_score), .p2_score(p2_score), .state_out(state_out),
        .winner(winner), .hit_pulse(hit_pulse), .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       tk;
        logic [7:0] j1;
        logic [7:0] j2;
        int e_st, e_bx, e_by, e_p1, e_p2, e_s1, e_s2, e_hit, e_pt;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame tick; returns at the following negedge with results visible
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic press();
        @(negedge clk);
        start = 1'b1;
        idle(3);
        start = 1'b0;
        idle(2);
    endtask

    function automatic int y_after_hit(input int m);
        if (m <= 26) return 391 + 3 * m;
        else return 470 - 3 * (m - 27);
    endfunction

    initial begin
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0; joy_y1 = 8'd128; joy_y2 = 8'd128;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset.winner", winner, 0);

        vt[0]  = '{1'b0, 1'b0, 8'd128, 8'd128, 0, 315, 235, 190, 190, 0, 0, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 8'd128, 8'd128, 0, 315, 235, 190, 190, 0, 0, 0, 0};
        vt[2]  = '{1'b1, 1'b1, 8'd128, 8'd128, 1, 315, 235, 190, 190, 0, 0, 0, 0};
        vt[3]  = '{1'b0, 1'b1, 8'd128, 8'd128, 1, 315, 235, 190, 190, 0, 0, 0, 0};
        vt[4]  = '{1'b1, 1'b1, 8'd128, 8'd128, 2, 315, 235, 190, 190, 0, 0, 0, 0};
        vt[5]  = '{1'b0, 1'b1, 8'd255, 8'd0,   2, 309, 238, 187, 194, 0, 0, 0, 0};
        vt[6]  = '{1'b0, 1'b1, 8'd128, 8'd128, 2, 303, 241, 187, 194, 0, 0, 0, 0};
        vt[7]  = '{1'b0, 1'b1, 8'd127, 8'd160, 2, 297, 244, 187, 193, 0, 0, 0, 0};
        vt[8]  = '{1'b1, 1'b1, 8'd128, 8'd128, 2, 291, 247, 187, 193, 0, 0, 0, 0};
        vt[9]  = '{1'b0, 1'b1, 8'd128, 8'd128, 2, 285, 250, 187, 193, 0, 0, 0, 0};
        vt[10] = '{1'b0, 1'b0, 8'd0,   8'd128, 2, 285, 250, 187, 193, 0, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = vt[i].st; joy_y1 = vt[i].j1; joy_y2 = vt[i].j2;
            idle(3);
            if (vt[i].tk) do_tick();
            else idle(1);
            chk($sformatf("v%0d.state", i), state_out, vt[i].e_st);
            chk($sformatf("v%0d.ball_x", i), ball_x, vt[i].e_bx);
            chk($sformatf("v%0d.ball_y", i), ball_y, vt[i].e_by);
            chk($sformatf("v%0d.p1_y", i), p1_y, vt[i].e_p1);
            chk($sformatf("v%0d.p2_y", i), p2_y, vt[i].e_p2);
            chk($sformatf("v%0d.p1_score", i), p1_score, vt[i].e_s1);
            chk($sformatf("v%0d.p2_score", i), p2_score, vt[i].e_s2);
            chk($sformatf("v%0d.hit", i), hit_pulse, vt[i].e_hit);
            chk($sformatf("v%0d.point", i), point_pulse, vt[i].e_pt);
        end

        // Ball travels left while p1 slides down into its path
        joy_y1 = 8'd0; joy_y2 = 8'd128;
        for (int k = 1; k <= 46; k++) begin
            do_tick();
            chk($sformatf("lft%0d.p1_y", k), p1_y, 187 + 4 * k);
            chk($sformatf("lft%0d.ball_x", k), ball_x, 285 - 6 * k);
            chk($sformatf("lft%0d.ball_y", k), ball_y, 250 + 3 * k);
            chk($sformatf("lft%0d.hit", k), hit_pulse, 0);
        end
        do_tick();
        chk("lhit.ball_x", ball_x, 5);
        chk("lhit.ball_y", ball_y, 391);
        chk("lhit.p1_y", p1_y, 375);
        chk("lhit.hit", hit_pulse, 1);
        chk("lhit.p2_score", p2_score, 0);
        chk("lhit.state", state_out, 2);
        idle(1);
        chk("lhit.hit_drop", hit_pulse, 0);

`ifdef PONG_BALL_SPEEDUP_EN
        do_tick();
        chk("spd.ball_x1", ball_x, 12);
        do_tick();
        chk("spd.ball_x2", ball_x, 19);
`else
        // Ball returns right, bounces off the bottom and passes p2 parked at the top
        joy_y2 = 8'd255;
        for (int m = 1; m <= 103; m++) begin
            do_tick();
            chk($sformatf("rgt%0d.ball_x", m), ball_x, 5 + 6 * m);
            chk($sformatf("rgt%0d.ball_y", m), ball_y, y_after_hit(m));
            chk($sformatf("rgt%0d.p1_y", m), p1_y, (375 + 4 * m > 380) ? 380 : 375 + 4 * m);
            chk($sformatf("rgt%0d.p2_y", m), p2_y, (193 - 3 * m < 0) ? 0 : 193 - 3 * m);
            chk($sformatf("rgt%0d.point", m), point_pulse, 0);
        end
        do_tick();
        chk("rmiss.point", point_pulse, 1);
        chk("rmiss.p1_score", p1_score, 1);
        chk("rmiss.p2_score", p2_score, 0);
        chk("rmiss.state", state_out, 1);
        chk("rmiss.hit", hit_pulse, 0);

        // Six more right-side misses: serve heads right toward the last loser
        joy_y1 = 8'd128;
        for (int r = 2; r <= 7; r++) begin
            press();
            do_tick();
            chk($sformatf("r%0d.serve_state", r), state_out, 2);
            chk($sformatf("r%0d.serve_x", r), ball_x, 315);
            chk($sformatf("r%0d.serve_p2", r), p2_y, 190);
            for (int k = 1; k <= 51; k++) begin
                do_tick();
                chk($sformatf("r%0d.k%0d.ball_x", r, k), ball_x, 315 + 6 * k);
                chk($sformatf("r%0d.k%0d.ball_y", r, k), ball_y, 235 + 3 * k);
            end
            do_tick();
            chk($sformatf("r%0d.point", r), point_pulse, 1);
            chk($sformatf("r%0d.p1_score", r), p1_score, r);
            chk($sformatf("r%0d.state", r), state_out, (r == 7) ? 3 : 1);
        end
        chk("go.winner", winner, 0);
        chk("go.p2_score", p2_score, 0);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            chk($sformatf("go%0d.state", k), state_out, 3);
            chk($sformatf("go%0d.ball_x", k), ball_x, 621);
            chk($sformatf("go%0d.ball_y", k), ball_y, 391);
            chk($sformatf("go%0d.p2_y", k), p2_y, 34);
            chk($sformatf("go%0d.p1_score", k), p1_score, 7);
        end
        press();
        do_tick();
        chk("restart.state", state_out, 0);
        chk("restart.p1_score", p1_score, 0);
        chk("restart.p2_score", p2_score, 0);
        do_tick();
        chk("idle.ball_x", ball_x, 315);
        chk("idle.ball_y", ball_y, 235);

        // p2 returns the serve, then the ball slips past p1 pinned at the top
        joy_y1 = 8'd255; joy_y2 = 8'd0;
        press();
        do_tick();
        chk("g2.serve", state_out, 1);
        press();
        do_tick();
        chk("g2.play", state_out, 2);
        for (int k = 1; k <= 51; k++) do_tick();
        do_tick();
        chk("rhit.hit", hit_pulse, 1);
        chk("rhit.ball_x", ball_x, 625);
        chk("rhit.p2_y", p2_y, 380);
        for (int j = 1; j <= 103; j++) begin
            do_tick();
            chk($sformatf("back%0d.ball_x", j), ball_x, 625 - 6 * j);
            chk($sformatf("back%0d.ball_y", j), ball_y, y_after_hit(j));
            chk($sformatf("back%0d.p1_y", j), p1_y, (34 - 3 * j < 0) ? 0 : 34 - 3 * j);
        end
        do_tick();
        chk("lmiss.point", point_pulse, 1);
        chk("lmiss.p2_score", p2_score, 1);
        chk("lmiss.p1_score", p1_score, 0);
        chk("lmiss.state", state_out, 1);
        press();
        do_tick();
        do_tick();
        chk("lserve.ball_x", ball_x, 309);
`endif

        // Synchronous reset mid-PLAY with no frame tick; start held across reset
        @(negedge clk);
        chk("pre_rst.state", state_out, 2);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst.state", state_out, 0);
        chk("rst.ball_x", ball_x, 315);
        chk("rst.ball_y", ball_y, 235);
        chk("rst.p1_y", p1_y, 190);
        chk("rst.p2_y", p2_y, 190);
        chk("rst.p1_score", p1_score, 0);
        chk("rst.p2_score", p2_score, 0);
        chk("rst.winner", winner, 0);
        chk("rst.hit", hit_pulse, 0);
        chk("rst.point", point_pulse, 0);
        idle(2);
        rst = 1'b0;
        idle(3);
        do_tick();
        chk("rst.no_spurious_start", state_out, 0);
        start = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_engine_param.md
Name: pong_engine_param

Overview:
- Parametrised, clocked successor to the frame-rate Pong state updater.
- Runs on the system clock and advances game physics once per `frame_tick` pulse, not on the vsync edge.
- Resolution, paddle/ball geometry, serve speed and winning score are parameters.
- Adds a GAME_OVER state, serve direction toward the last loser, position-clamped bounces, and event pulses for sound/LED logic.

Parameters:
- H_RES, 640, screen width in pixels
- V_RES, 480, screen height in pixels
- POS_W, 11, position width in bits
- PADDLE_H, 100, paddle height
- PADDLE_W, 5, paddle width; paddles occupy x in [0,PADDLE_W) and [H_RES-PADDLE_W,H_RES)
- BALL_SIZE, 10, ball edge length (square)
- BALL_VX0, 6, serve x speed in pixels/frame
- BALL_VY0, 3, y speed in pixels/frame
- MAX_VX, 15, x speed ceiling (speedup option)
- SPEED_SHIFT, 5, joystick step = |joy-128| >> SPEED_SHIFT
- SCORE_W, 8, score width
- WIN_SCORE, 7, points that end the game

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- frame_tick  in  1  one-clk pulse per frame; physics updates only on this
- start  in  1  level button; rising edge detected internally
- joy_y1  in  8  player 1 stick Y; 128 is centre, >128 means up
- joy_y2  in  8  player 2 stick Y
- ball_x  out  POS_W  ball top-left x
- ball_y  out  POS_W  ball top-left y
- p1_y  out  POS_W  left paddle top y
- p2_y  out  POS_W  right paddle top y
- p1_score  out  SCORE_W  player 1 score
- p2_score  out  SCORE_W  player 2 score
- state_out  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 GAME_OVER
- winner  out  1  0 = P1, 1 = P2; valid in GAME_OVER
- hit_pulse  out  1  one clk high on any paddle hit
- point_pulse  out  1  one clk high on any score

Behaviour:
- Reset: rst is synchronous, active-high; it overrides everything.
  - state = IDLE, scores = 0, winner = 0, pulses = 0.
  - Ball at centre: CX = H_RES/2-BALL_SIZE/2 (315), CY = V_RES/2-BALL_SIZE/2 (235).
  - Paddles at PY0 = (V_RES-PADDLE_H)/2 (190).
  - vx = BALL_VX0, vy = BALL_VY0, x direction = LEFT, y direction = DOWN, serve_dir = LEFT.
- Start edge:
  - start_evt = start & ~start_q, registered every clk.
  - It latches a pending flag, cleared when consumed on a frame_tick.
  - Events during rst are discarded.
- All state, position and score updates occur in the clk cycle where frame_tick = 1, so there is one frame of latency.
- Outputs are registered. Pulses are high for exactly one clk, in the tick cycle.
- IDLE:
  - Hold centre positions; scores = 0.
  - Pending start → SERVE.
- SERVE:
  - Ball to (CX,CY), paddles to PY0, vx = BALL_VX0, x direction = serve_dir, y direction = DOWN.
  - Pending start → PLAY.
- PLAY, per tick:
  - Paddles:
    - step = |joy-128| >> SPEED_SHIFT.
    - Joy ≥ 128 moves up; y = max(y-step, 0) (no underflow).
    - Joy < 128 moves down; y = min(y+step, V_RES-PADDLE_H).
  - Paddle hit/miss uses the old paddle y.
  - Left-moving ball, when ball_x < PADDLE_W+vx:
    - Overlap is ball_y+BALL_SIZE > p1_y && ball_y < p1_y+PADDLE_H.
    - Hit: ball_x = PADDLE_W, direction RIGHT, hit_pulse.
    - Miss: p2_score+1, point_pulse, serve_dir = LEFT.
  - Right-moving ball: symmetric.
    - Trigger is ball_x+BALL_SIZE+vx > H_RES-PADDLE_W.
    - Hit: ball_x = H_RES-PADDLE_W-BALL_SIZE.
    - Miss: p1_score+1, serve_dir = RIGHT.
  - Vertical bounces:
    - DOWN with ball_y+BALL_SIZE+vy ≥ V_RES: ball_y = V_RES-BALL_SIZE, direction UP.
    - UP with ball_y < vy: ball_y = 0, direction DOWN.
    - Otherwise ball_y ± vy.
  - Corner case: x and y reflections in the same tick both apply.
  - After a miss: the new score == WIN_SCORE → GAME_OVER (winner set); else → SERVE.
  - Scores saturate and never wrap.
  - A start pressed during PLAY is ignored, and its pending flag is cleared.
- GAME_OVER:
  - Freeze all positions and scores.
  - Pending start → IDLE, which clears the scores.
- Illegal state → IDLE.

Optional Feature:
- Macro: PONG_BALL_SPEEDUP_EN.
- Defined: each paddle hit sets vx = min(vx+1, MAX_VX); SERVE restores BALL_VX0.
- Undefined: vx is constant at BALL_VX0 and MAX_VX is unused.

Decomposition:
- Package pong_pkg:
  - state enum (IDLE, SERVE, PLAY, GAME_OVER)
  - dir_t constants LEFT/RIGHT and UP/DOWN
  - joystick centre constant 128
- One sub-module, pong_paddle_mover:
  - Inputs: joy, current y, frame_tick.
  - Computes the step and the clamped next y.
  - Instantiated twice.

Test Plan:
- Reset, then start pressed, tick, released, pressed, tick → state 0 → 1 → 2; ball (315,235), paddles 190.
- PLAY with joy_y1 = 255, 100 ticks → p1_y decrements by 3 per tick, then clamps at 0 and never wraps. joy_y1 = 0 → clamps at 380.
- Ball moving left, p1_y = 190, ball_y = 235, ball_x = 8, vx = 6 → next tick ball_x = 5, direction RIGHT, hit_pulse once, scores unchanged.
- Same setup with p1_y = 0 → p2_score = 1, point_pulse, state SERVE, next serve heads LEFT.
- p1_score = 6 and right-side miss → p1_score = 7, state 3, winner = 0. A start press then gives IDLE with scores 0.
- With PONG_BALL_SPEEDUP_EN: 12 consecutive hits → vx reaches 15 and stays there. rst mid-PLAY → all outputs return to reset values in the next clk, independent of frame_tick.
